// File: rtl/sound_mailbox.sv
// sound_mailbox: command FIFO (68000 -> 6502) with NMI pulse per accepted command,
// plus an optional reply FIFO (6502 -> 68000) built when SOUND_MAILBOX_REPLY_EN is defined.
// Both FIFOs are show-ahead: dout presents the head entry, a read strobe pops it.
module sound_mailbox #(
  parameter int unsigned DW        = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NMI_PULSE = 4
) (
  input  logic                         phi0,
  input  logic                         SNDRST_b,
  input  logic                         main_wr,
  input  logic [DW-1:0]                main_din,
  input  logic                         main_rd,
  output logic [DW-1:0]                main_dout,
  output logic                         main_full,
  output logic                         main_avail,
  input  logic                         snd_rd,
  output logic [DW-1:0]                snd_dout,
  input  logic                         snd_wr,
  input  logic [DW-1:0]                snd_din,
  input  logic                         snd_clr,
  output logic [3:0]                   snd_status,
  output logic [$clog2(DEPTH+1)-1:0]   cmd_count,
  output logic                         SNDNMI_b
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned NW = $clog2(NMI_PULSE+1);

  // ---------------- command FIFO ----------------
  logic [DW-1:0] cmd_mem_q [DEPTH];
  logic [PW-1:0] cmd_wptr_q, cmd_rptr_q;
  logic [CW-1:0] cmd_cnt_q, cmd_cnt_d;
  logic          cmd_ovf_q, cmd_full, cmd_empty, cmd_pop, cmd_push, cmd_drop;

  assign cmd_full  = (cmd_cnt_q == CW'(DEPTH));
  assign cmd_empty = (cmd_cnt_q == '0);
  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign cmd_pop   = snd_rd & ~cmd_empty;
  assign cmd_push  = main_wr & (~cmd_full | cmd_pop);
  assign cmd_drop  = main_wr & cmd_full & ~snd_rd;

  // Command occupancy next-state.
  always_comb begin
    cmd_cnt_d = cmd_cnt_q;
    if (cmd_push && !cmd_pop)      cmd_cnt_d = cmd_cnt_q + CW'(1);
    else if (cmd_pop && !cmd_push) cmd_cnt_d = cmd_cnt_q - CW'(1);
  end

  // Command storage, pointers, count and sticky overflow.
  always_ff @(posedge phi0 or negedge SNDRST_b) begin
    if (!SNDRST_b) begin
      for (int i = 0; i < int'(DEPTH); i++) cmd_mem_q[i] <= '0;
      cmd_wptr_q <= '0;
      cmd_rptr_q <= '0;
      cmd_cnt_q  <= '0;
      cmd_ovf_q  <= 1'b0;
    end else begin
      if (cmd_push) begin
        cmd_mem_q[cmd_wptr_q] <= main_din;
        cmd_wptr_q            <= cmd_wptr_q + PW'(1);
      end
      if (cmd_pop) cmd_rptr_q <= cmd_rptr_q + PW'(1);
      cmd_cnt_q <= cmd_cnt_d;
      // A new overflow beats a coincident clear.
      cmd_ovf_q <= cmd_drop | (cmd_ovf_q & ~snd_clr);
    end
  end

  assign snd_dout  = cmd_empty ? '0 : cmd_mem_q[cmd_rptr_q];
  assign cmd_count = cmd_cnt_q;
  assign main_full = cmd_full;

  // ---------------- NMI pulse ----------------
  logic [NW-1:0] nmi_cnt_q, nmi_cnt_d;
  logic          nmi_b_q;

  // Reload on every accepted command, otherwise count down to zero.
  always_comb begin
    nmi_cnt_d = nmi_cnt_q;
    if (cmd_push)               nmi_cnt_d = NW'(NMI_PULSE);
    else if (nmi_cnt_q != '0)   nmi_cnt_d = nmi_cnt_q - NW'(1);
  end

  // NMI counter and registered active-low output.
  always_ff @(posedge phi0 or negedge SNDRST_b) begin
    if (!SNDRST_b) begin
      nmi_cnt_q <= '0;
      nmi_b_q   <= 1'b1;
    end else begin
      nmi_cnt_q <= nmi_cnt_d;
      nmi_b_q   <= (nmi_cnt_d == '0);
    end
  end

  assign SNDNMI_b = nmi_b_q;

  // ---------------- reply FIFO ----------------
  logic rep_ovf, rep_full;

`ifdef SOUND_MAILBOX_REPLY_EN
  logic [DW-1:0] rep_mem_q [DEPTH];
  logic [PW-1:0] rep_wptr_q, rep_rptr_q;
  logic [CW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_ovf_q, rep_empty, rep_pop, rep_push, rep_drop;

  assign rep_full  = (rep_cnt_q == CW'(DEPTH));
  assign rep_empty = (rep_cnt_q == '0);
  assign rep_pop   = main_rd & ~rep_empty;
  assign rep_push  = snd_wr & (~rep_full | rep_pop);
  assign rep_drop  = snd_wr & rep_full & ~main_rd;

  // Reply occupancy next-state.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    if (rep_push && !rep_pop)      rep_cnt_d = rep_cnt_q + CW'(1);
    else if (rep_pop && !rep_push) rep_cnt_d = rep_cnt_q - CW'(1);
  end

  // Reply storage, pointers, count and sticky overflow.
  always_ff @(posedge phi0 or negedge SNDRST_b) begin
    if (!SNDRST_b) begin
      for (int i = 0; i < int'(DEPTH); i++) rep_mem_q[i] <= '0;
      rep_wptr_q <= '0;
      rep_rptr_q <= '0;
      rep_cnt_q  <= '0;
      rep_ovf_q  <= 1'b0;
    end else begin
      if (rep_push) begin
        rep_mem_q[rep_wptr_q] <= snd_din;
        rep_wptr_q            <= rep_wptr_q + PW'(1);
      end
      if (rep_pop) rep_rptr_q <= rep_rptr_q + PW'(1);
      rep_cnt_q <= rep_cnt_d;
      rep_ovf_q <= rep_drop | (rep_ovf_q & ~snd_clr);
    end
  end

  assign rep_ovf    = rep_ovf_q;
  assign main_dout  = rep_empty ? '0 : rep_mem_q[rep_rptr_q];
  assign main_avail = ~rep_empty;
`else
  // No reply path: its inputs are intentionally left unconsumed.
  logic unused_reply;
  assign unused_reply = ^{main_rd, snd_wr, snd_din};
  assign rep_ovf      = 1'b0;
  assign rep_full     = 1'b0;
  assign main_dout    = '0;
  assign main_avail   = 1'b0;
`endif

  assign snd_status = {rep_ovf, cmd_ovf_q, rep_full, ~cmd_empty};

endmodule

// File: tb/tb_sound_mailbox.sv
// Self-checking bench for sound_mailbox: queue-based model, per-cycle compare process,
// directed literal checks, then randomized traffic with occasional async resets.
module tb_sound_mailbox;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int NMI_PULSE = 4;
  localparam int CW = $clog2(DEPTH + 1);
`ifdef SOUND_MAILBOX_REPLY_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic          phi0, SNDRST_b;
  logic          main_wr, main_rd, snd_rd, snd_wr, snd_clr;
  logic [DW-1:0] main_din, snd_din, main_dout, snd_dout;
  logic          main_full, main_avail, SNDNMI_b;
  logic [3:0]    snd_status;
  logic [CW-1:0] cmd_count;

  sound_mailbox #(.DW(DW), .DEPTH(DEPTH), .NMI_PULSE(NMI_PULSE)) dut (
    .phi0(phi0), .SNDRST_b(SNDRST_b),
    .main_wr(main_wr), .main_din(main_din), .main_rd(main_rd), .main_dout(main_dout),
    .main_full(main_full), .main_avail(main_avail),
    .snd_rd(snd_rd), .snd_dout(snd_dout), .snd_wr(snd_wr), .snd_din(snd_din),
    .snd_clr(snd_clr), .snd_status(snd_status), .cmd_count(cmd_count), .SNDNMI_b(SNDNMI_b)
  );

  initial phi0 = 1'b0;
  always #5 phi0 = ~phi0;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] cq[$];
  logic [DW-1:0] rq[$];
  bit m_cmd_ovf, m_rep_ovf;
  int nmi_left;

  function automatic void model_reset();
    cq.delete();
    rq.delete();
    m_cmd_ovf = 0;
    m_rep_ovf = 0;
    nmi_left  = 0;
  endfunction

  // One clock edge worth of FIFO rules applied to the queues.
  function automatic void model_step(input bit wr, input logic [DW-1:0] din, input bit mrd,
                                     input bit swr, input logic [DW-1:0] sdin, input bit srd,
                                     input bit clr);
    bit full, pop, push, ovf;
    full = (cq.size() == DEPTH);
    pop  = srd && cq.size() > 0;
    push = wr && (!full || pop);
    ovf  = wr && full && !srd;
    if (pop) void'(cq.pop_front());
    if (push) cq.push_back(din);
    if (push) nmi_left = NMI_PULSE;
    else if (nmi_left > 0) nmi_left--;
    m_cmd_ovf = ovf || (m_cmd_ovf && !clr);
    if (REP) begin
      full = (rq.size() == DEPTH);
      pop  = mrd && rq.size() > 0;
      push = swr && (!full || pop);
      ovf  = swr && full && !mrd;
      if (pop) void'(rq.pop_front());
      if (push) rq.push_back(sdin);
      m_rep_ovf = ovf || (m_rep_ovf && !clr);
    end
  endfunction

  // Compare every output against the model once per cycle, away from the active edge.
  always @(negedge phi0) begin
    if (cmp_en) begin
      logic [DW-1:0] e_sd, e_md;
      e_sd = (cq.size() > 0) ? cq[0] : '0;
      e_md = (rq.size() > 0) ? rq[0] : '0;
      chk("snd_dout", snd_dout, e_sd);
      chk("main_dout", main_dout, e_md);
      chk("cmd_count", cmd_count, cq.size());
      chk("main_full", main_full, cq.size() == DEPTH);
      chk("main_avail", main_avail, rq.size() > 0);
      chk("snd_status", snd_status,
          {m_rep_ovf, m_cmd_ovf, rq.size() == DEPTH, cq.size() > 0});
      chk("SNDNMI_b", SNDNMI_b, nmi_left == 0);
    end
  end

  // Drive one cycle of inputs; returns at the following falling edge.
  task automatic cyc(input bit wr, input logic [DW-1:0] din, input bit mrd, input bit swr,
                     input logic [DW-1:0] sdin, input bit srd, input bit clr);
    main_wr = wr; main_din = din; main_rd = mrd;
    snd_wr = swr; snd_din = sdin; snd_rd = srd; snd_clr = clr;
    @(posedge phi0);
    model_step(wr, din, mrd, swr, sdin, srd, clr);
    @(negedge phi0);
  endtask

  task automatic idle();
    cyc(0, '0, 0, 0, '0, 0, 0);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic rst_pulse();
    main_wr = 0; main_rd = 0; snd_wr = 0; snd_rd = 0; snd_clr = 0;
    #2 SNDRST_b = 1'b0;
    #1;
    chk("rst_cmd_count", cmd_count, 0);
    chk("rst_status", snd_status, 0);
    chk("rst_nmi", SNDNMI_b, 1);
    chk("rst_snd_dout", snd_dout, 0);
    chk("rst_main_avail", main_avail, 0);
    model_reset();
    #1 SNDRST_b = 1'b1;
  endtask

  initial begin
    int lows;
    SNDRST_b = 1'b0;
    main_wr = 0; main_rd = 0; snd_wr = 0; snd_rd = 0; snd_clr = 0;
    main_din = '0; snd_din = '0;
    model_reset();
    @(negedge phi0);
    rst_pulse();
    cmp_en = 1'b1;

    // Single command, NMI width.
    cyc(1, 8'h5A, 0, 0, '0, 0, 0);
    chk("first_dout", snd_dout, 8'h5A);
    chk("first_count", cmd_count, 1);
    lows = (SNDNMI_b == 1'b0) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      idle();
      if (SNDNMI_b == 1'b0) lows++;
      else break;
    end
    chk("nmi_low_cycles", lows, 4);
    cyc(0, '0, 0, 0, '0, 1, 0);

    // Fill, overflow, drain.
    for (int i = 1; i <= 4; i++) cyc(1, DW'(i), 0, 0, '0, 0, 0);
    chk("full_flag", main_full, 1);
    cyc(1, 8'h05, 0, 0, '0, 0, 0);
    chk("cmd_ovf_set", snd_status[2], 1);
    chk("count_after_drop", cmd_count, 4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", snd_dout, i);
      cyc(0, '0, 0, 0, '0, 1, 0);
    end
    chk("empty_dout", snd_dout, 0);
    chk("empty_avail", snd_status[0], 0);
    chk("ovf_sticky", snd_status[2], 1);
    cyc(0, '0, 0, 0, '0, 0, 1);
    chk("ovf_cleared", snd_status[2], 0);

    // Simultaneous push/pop on full.
    for (int i = 1; i <= 4; i++) cyc(1, DW'(i), 0, 0, '0, 0, 0);
    cyc(1, 8'h77, 0, 0, '0, 1, 0);
    chk("full_rw_count", cmd_count, 4);
    chk("full_rw_no_ovf", snd_status[2], 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("full_rw_last", snd_dout, 8'h77);
      cyc(0, '0, 0, 0, '0, 1, 0);
    end

    // Simultaneous push/pop on empty.
    cyc(1, 8'h33, 0, 0, '0, 1, 0);
    chk("empty_rw_count", cmd_count, 1);
    chk("empty_rw_dout", snd_dout, 8'h33);
    cyc(0, '0, 0, 0, '0, 1, 0);

    // Retriggered NMI: writes two cycles apart give 6 low cycles.
    for (int i = 0; i < 6; i++) idle();
    lows = 0;
    cyc(1, 8'h01, 0, 0, '0, 0, 0);
    if (SNDNMI_b == 1'b0) lows++;
    idle();
    if (SNDNMI_b == 1'b0) lows++;
    cyc(1, 8'h02, 0, 0, '0, 0, 0);
    if (SNDNMI_b == 1'b0) lows++;
    for (int i = 0; i < 10; i++) begin
      idle();
      if (SNDNMI_b == 1'b0) lows++;
      else break;
    end
    chk("nmi_retrigger_low", lows, 6);
    cyc(0, '0, 0, 0, '0, 1, 0);
    cyc(0, '0, 0, 0, '0, 1, 0);

    // Reply path.
    cyc(0, '0, 0, 1, 8'hA5, 0, 0);
    chk("reply_avail", main_avail, REP);
    chk("reply_dout", main_dout, REP ? 8'hA5 : 8'h00);
    cyc(0, '0, 1, 0, '0, 0, 0);
    chk("reply_drained", main_avail, 0);

    // Reset mid-transfer.
    for (int i = 0; i < 3; i++) cyc(1, DW'(8'h40 + i), 0, 1, 8'h10, 0, 0);
    rst_pulse();
    idle();
    chk("post_rst_count", cmd_count, 0);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_pulse();
        idle();
      end else begin
        cyc($urandom_range(0, 99) < 55, DW'($urandom), $urandom_range(0, 99) < 40,
            $urandom_range(0, 99) < 55, DW'($urandom), $urandom_range(0, 99) < 40,
            $urandom_range(0, 99) < 5);
      end
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
